// File: rtl/mul_iter_unit_pkg.sv
// Shared definitions for the iterative multiplier: FSM states, multiply/accumulator
// function codes and classification helpers.
package mul_iter_unit_pkg;

   localparam int FUNC_W = 6;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [FUNC_W-1:0] FN_MADD  = 6'h00;
   localparam logic [FUNC_W-1:0] FN_MADDU = 6'h01;
   localparam logic [FUNC_W-1:0] FN_MSUB  = 6'h04;
   localparam logic [FUNC_W-1:0] FN_MSUBU = 6'h05;
   localparam logic [FUNC_W-1:0] FN_MFHI  = 6'h10;
   localparam logic [FUNC_W-1:0] FN_MTHI  = 6'h11;
   localparam logic [FUNC_W-1:0] FN_MFLO  = 6'h12;
   localparam logic [FUNC_W-1:0] FN_MTLO  = 6'h13;
   localparam logic [FUNC_W-1:0] FN_MULT  = 6'h18;
   localparam logic [FUNC_W-1:0] FN_MULTU = 6'h19;

   function automatic logic is_signed(input logic [FUNC_W-1:0] f);
      return (f == FN_MULT) || (f == FN_MADD) || (f == FN_MSUB);
   endfunction

   // HI/LO moves skip the shift-add datapath entirely
   function automatic logic is_bypass(input logic [FUNC_W-1:0] f);
      return (f == FN_MFHI) || (f == FN_MFLO) || (f == FN_MTHI) || (f == FN_MTLO);
   endfunction

endpackage

// File: rtl/mul_iter_unit_if.sv
// Issue-side handshake and result bus between the issue stage and the multiplier.
interface mul_iter_unit_if import mul_iter_unit_pkg::*; ();
   logic              start;
   logic              flush;
   logic [FUNC_W-1:0] mul_func;
   logic [31:0]       a;
   logic [31:0]       b;
   logic              busy;
   logic              valid;
   logic [FUNC_W-1:0] func_out;
   logic [63:0]       product;

   modport master (output start, flush, mul_func, a, b,
                   input  busy, valid, func_out, product);
   modport slave  (input  start, flush, mul_func, a, b,
                   output busy, valid, func_out, product);
endinterface

// File: rtl/mul_iter_unit_step.sv
// One shift-add iteration: adds multiplicand * ITER_BITS-wide multiplier slice
// into the 66-bit accumulator.
module mul_iter_unit_step #(
   parameter int ITER_BITS = 1
) (
   input  logic [65:0]          i_acc,
   input  logic [63:0]          i_mcand,
   input  logic [ITER_BITS-1:0] i_slice,
   output logic [65:0]          o_acc
);

   logic [65:0] w_pp;

   always_comb begin
      w_pp = '0;
      for (int i = 0; i < ITER_BITS; i++) begin
         if (i_slice[i]) w_pp = w_pp + ({2'b00, i_mcand} << i);
      end
      o_acc = i_acc + w_pp;
   end

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative 32x32 multiplier feeding the HI/LO accumulator (Valid = accumulator enable).
// Optional MUL_EARLY_OUT_EN: finish as soon as the remaining multiplier bits are zero.
module mul_iter_unit import mul_iter_unit_pkg::*; #(
   parameter int ITER_BITS = 1
) (
   input logic          i_clk,
   input logic          i_rst,
   mul_iter_unit_if.slave io_bus
);

   localparam int N = 32 / ITER_BITS;
   localparam logic [5:0] LAST = 6'(N - 1);

   state_t            r_state, w_next_state;
   logic [65:0]       r_acc;
   logic [63:0]       r_mcand;
   logic [31:0]       r_mplier;
   logic              r_sign;
   logic [5:0]        r_cnt;
   logic [FUNC_W-1:0] r_func;
   logic [63:0]       r_product;

   logic [65:0] w_step;
   logic [63:0] w_final, w_fixed;
   logic [31:0] w_abs_a, w_abs_b;
   logic        w_sgn_op, w_accept, w_last, w_early, w_mdone;

   assign w_accept = io_bus.start && !io_bus.flush && (r_state == IDLE || r_state == DONE);
   assign w_sgn_op = is_signed(io_bus.mul_func);
   assign w_abs_a  = (w_sgn_op && io_bus.a[31]) ? -io_bus.a : io_bus.a;
   assign w_abs_b  = (w_sgn_op && io_bus.b[31]) ? -io_bus.b : io_bus.b;
   assign w_last   = (r_cnt == LAST);

`ifdef MUL_EARLY_OUT_EN
   assign w_early = (r_mplier == '0);
`else
   assign w_early = 1'b0;
`endif

   assign w_mdone = w_early || w_last;
   // Early exit skips the step, so the sign fix is applied to the held accumulator
   assign w_final = w_early ? r_acc[63:0] : w_step[63:0];
   assign w_fixed = r_sign ? -w_final : w_final;

   mul_iter_unit_step #(.ITER_BITS(ITER_BITS)) u_step (
      .i_acc   (r_acc),
      .i_mcand (r_mcand),
      .i_slice (r_mplier[ITER_BITS-1:0]),
      .o_acc   (w_step)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      if (io_bus.flush) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (io_bus.start) w_next_state = is_bypass(io_bus.mul_func) ? DONE : BUSY;
               else              w_next_state = IDLE;
            end
            BUSY:    if (w_mdone) w_next_state = DONE;
            default: w_next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_sign    <= 1'b0;
         r_cnt     <= '0;
         r_func    <= '0;
         r_product <= '0;
      end else if (w_accept) begin
         r_func   <= io_bus.mul_func;
         r_acc    <= '0;
         r_mcand  <= {32'd0, w_abs_a};
         r_mplier <= w_abs_b;
         r_sign   <= w_sgn_op && (io_bus.a[31] ^ io_bus.b[31]);
         r_cnt    <= '0;
         if (is_bypass(io_bus.mul_func)) r_product <= {32'd0, io_bus.a};
      end else if (r_state == BUSY && !io_bus.flush) begin
         r_acc    <= w_step;
         r_mcand  <= r_mcand << ITER_BITS;
         r_mplier <= r_mplier >> ITER_BITS;
         r_cnt    <= r_cnt + 6'd1;
         if (w_mdone) r_product <= w_fixed;
      end
   end

   assign io_bus.busy     = (r_state == BUSY);
   assign io_bus.valid    = (r_state == DONE) && !io_bus.flush;
   assign io_bus.func_out = r_func;
   assign io_bus.product  = r_product;

endmodule
